multi_ch_timer_fsm: RTL and testbench
=====================================

# multi_ch_timer_fsm

Multi-channel, parametrised successor to the single-channel fixed-length activity counter. Each of `N_CH` independent channels runs a timed active window. The window length is supplied at run time. Each channel selects one-shot, retriggerable or periodic mode, supports abort, and reports completion with a one-cycle pulse. The block sits beside the datapath as the shared timing source for gating windows, timeouts and periodic strobes, advancing on the common `i_ce` tick.

## Interface
- `N_CH`, 4: number of independent channels (≥1).
- `CNT_W`, 16: counter/length width per channel; max window 2^CNT_W−1 ticks.

- `i_clk` in 1: clock, rising edge.
- `i_nrst` in 1: asynchronous active-low reset.
- `i_ce` in 1: count tick enable, shared by all channels.
- `i_start` in N_CH: per-channel start request, sampled every cycle (level; one cycle suffices).
- `i_abort` in N_CH: per-channel abort, sampled every cycle.
- `i_len` in N_CH*CNT_W: window length per channel, slice [c*CNT_W +: CNT_W]; latched on accepted start.
- `i_mode` in 2*N_CH: per-channel mode, slice [2c +: 2]. 00 one-shot, 01 retrigger, 10 periodic, 11 treated as one-shot. Latched on accepted start.
- `o_active` out N_CH: channel in COUNT state (registered).
- `o_done` out N_CH: one-cycle completion pulse (registered).
- `o_count` out N_CH*CNT_W: current tick count per channel; 0 when idle.

## Operation
- Per-channel FSM, two states: IDLE, COUNT. Each channel has a latched length `len_q`, a latched mode `mode_q` and a counter `cnt`.
- Reset (async, `i_nrst`=0): all channels IDLE; `cnt`, `len_q`, `mode_q` = 0; `o_active`, `o_done`, `o_count` = 0.
- Priority per channel each cycle: abort > start > tick.

IDLE:
- If `i_abort`: stay IDLE.
- Else if `i_start` and `i_len`≠0: go to COUNT, `cnt`←0, latch `len_q`/`mode_q`.
- `i_start` with `i_len`=0 is ignored: stays IDLE, no `o_done`.

COUNT:
- `i_abort`: go to IDLE, `cnt`←0, no `o_done`.
- `i_start` in retrigger mode: `cnt`←0, relatch `len_q`/`mode_q`, stay COUNT, no `o_done`. This holds even if the same cycle is a terminal tick.
- `i_start` in one-shot or periodic mode: ignored.
- Tick (`i_ce`=1), `cnt`≠`len_q`−1: `cnt`←`cnt`+1.
- Terminal tick (`i_ce`=1, `cnt`=`len_q`−1), one-shot/retrigger: go to IDLE, `cnt`←0, `o_done`←1.
- Terminal tick, periodic: `cnt`←0, stay COUNT, `o_done`←1. Periodic runs until abort or reset.
- `i_ce`=0: state and `cnt` hold.

General rules:
- Arithmetic is unsigned CNT_W. `cnt` never exceeds `len_q`−1, so there is no wrap.
- Changing `i_len`/`i_mode` while a channel counts has no effect, except on an accepted retrigger.
- Channels are fully independent; only `i_ce` is shared.

## Timing
- `o_active`:
  - Rises at the edge that samples an accepted start; visible in cycle t+1 for a start at cycle t.
  - With `i_ce`≡1, one-shot stays high exactly `len_q` cycles and falls at the edge of the terminal tick.
  - Each stalled cycle (`i_ce`=0) extends the window by one cycle.
- `o_done`:
  - Asserted for exactly one cycle, following the edge that took the terminal tick. In one-shot/retrigger this is the first cycle `o_active` is low.
  - In periodic, `o_done` pulses once every `len_q` ticks while `o_active` stays 1.
- `o_count`: registered `cnt`; 0…`len_q`−1 while active.
- Abort: `o_active` drops one cycle after `i_abort` is sampled.
- Reset mid-count: outputs clear immediately (asynchronously), with no `o_done`.
- Start accepted in the same cycle `o_done` is high (one-shot back-to-back): allowed, no dead cycle required beyond the one IDLE cycle.

## Test plan
- Ch0 one-shot, len=5, `i_ce`≡1, start pulse at t=0 -> `o_active`[0] high t=1..5, `o_count` 0,1,2,3,4, `o_done`[0] high only at t=6; other channels stay 0.
- Ch1 retrigger, len=4, start at t=0 and t=2 -> `o_count` 0,1,0,1,2,3, `o_active` t=1..6, single `o_done` at t=7. Repeat with ch2 one-shot: second start ignored, done at t=5.
- Ch2 periodic, len=3, `i_ce`≡1, start at t=0, abort at t=10 -> `o_done` at t=4,7,10; `o_active` falls at t=11; no done at t=11.
- One-shot len=3 with `i_ce` toggling 1,0,1,0,… -> `o_active` lasts 6 cycles; `o_count` holds on `i_ce`=0 cycles; done once.
- Edge cases:
  - start with len=0 -> no activity.
  - start+abort same cycle in IDLE -> stays IDLE.
  - len=2^CNT_W−1 completes with no wrap.
- All 4 channels started with different len/modes simultaneously; async reset asserted mid-count (between clock edges) -> all outputs 0 immediately, restart after release behaves as from reset.

Source files
------------

// File: rtl/multi_ch_timer_fsm.sv
// Multi-channel window timer: N_CH independent one-shot / retrigger / periodic
// channels sharing a common count tick i_ce.

module multi_ch_timer_chan #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_ce,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_len,
  input  logic [1:0]       i_mode,
  output logic             o_active,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count
);
  typedef enum logic {S_IDLE, S_COUNT} state_e;

  localparam logic [1:0]       MODE_RETRIG = 2'b01;
  localparam logic [1:0]       MODE_PERIOD = 2'b10;
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, len_q;
  logic [1:0]       mode_q;
  logic             done_q;

  logic start_ok, terminal;
  assign start_ok = i_start && (i_len != '0);
  assign terminal = (cnt_q == len_q - ONE);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (!i_abort && start_ok) begin
          state_q <= S_COUNT;
          cnt_q   <= '0;
          len_q   <= i_len;
          mode_q  <= i_mode;
        end
      end else begin
        if (i_abort) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        // retrigger wins over a coincident terminal tick; zero length is not a valid window
        end else if (start_ok && mode_q == MODE_RETRIG) begin
          cnt_q  <= '0;
          len_q  <= i_len;
          mode_q <= i_mode;
        end else if (i_ce) begin
          if (terminal) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
            if (mode_q != MODE_PERIOD) state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
      end
    end
  end

  assign o_active = (state_q == S_COUNT);
  assign o_done   = done_q;
  assign o_count  = cnt_q;
endmodule

module multi_ch_timer_fsm #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ce,
  input  logic [N_CH-1:0]       i_start,
  input  logic [N_CH-1:0]       i_abort,
  input  logic [N_CH*CNT_W-1:0] i_len,
  input  logic [2*N_CH-1:0]     i_mode,
  output logic [N_CH-1:0]       o_active,
  output logic [N_CH-1:0]       o_done,
  output logic [N_CH*CNT_W-1:0] o_count
);
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    multi_ch_timer_chan #(.CNT_W(CNT_W)) u_ch (
      .i_clk   (i_clk),
      .i_nrst  (i_nrst),
      .i_ce    (i_ce),
      .i_start (i_start[c]),
      .i_abort (i_abort[c]),
      .i_len   (i_len[c*CNT_W +: CNT_W]),
      .i_mode  (i_mode[2*c +: 2]),
      .o_active(o_active[c]),
      .o_done  (o_done[c]),
      .o_count (o_count[c*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_multi_ch_timer_fsm.sv
// Scoreboard bench for multi_ch_timer_fsm: a window-level reference model pushes
// expected outputs per cycle; a monitor pops and compares after each rising edge.

module tb_multi_ch_timer_fsm;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  logic                  i_clk = 1'b0;
  logic                  i_nrst;
  logic                  i_ce;
  logic [N_CH-1:0]       i_start, i_abort;
  logic [N_CH*CNT_W-1:0] i_len;
  logic [2*N_CH-1:0]     i_mode;
  logic [N_CH-1:0]       o_active, o_done;
  logic [N_CH*CNT_W-1:0] o_count;

  multi_ch_timer_fsm #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_ce(i_ce), .i_start(i_start),
    .i_abort(i_abort), .i_len(i_len), .i_mode(i_mode),
    .o_active(o_active), .o_done(o_done), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [N_CH-1:0]       act;
    logic [N_CH-1:0]       done;
    logic [N_CH*CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model: a channel is either running a window of m_len ticks with
  // m_el ticks elapsed, or not running
  bit m_busy[N_CH];
  int m_el[N_CH];
  int m_len[N_CH];
  int m_mode[N_CH];
  int in_len[N_CH];
  int in_mode[N_CH];

  function automatic void model_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_busy[c] = 0; m_el[c] = 0; m_len[c] = 0; m_mode[c] = 0;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  task automatic set_ch(input int c, input int len, input int mode);
    in_len[c]  = len;
    in_mode[c] = mode;
  endtask

  // one clock cycle of stimulus; the model computes what the DUT must show after this edge
  task automatic step(input bit ce, input logic [N_CH-1:0] st, input logic [N_CH-1:0] ab);
    exp_t e;
    @(negedge i_clk);
    i_ce = ce; i_start = st; i_abort = ab;
    for (int c = 0; c < N_CH; c++) begin
      i_len[c*CNT_W +: CNT_W] = in_len[c][CNT_W-1:0];
      i_mode[2*c +: 2]        = in_mode[c][1:0];
    end
    e = '0;
    for (int c = 0; c < N_CH; c++) begin
      bit fired = 0;
      if (ab[c]) begin
        m_busy[c] = 0; m_el[c] = 0;
      end else if (!m_busy[c]) begin
        if (st[c] && in_len[c] != 0) begin
          m_busy[c] = 1; m_el[c] = 0; m_len[c] = in_len[c]; m_mode[c] = in_mode[c];
        end
      end else if (st[c] && m_mode[c] == 1 && in_len[c] != 0) begin
        m_el[c] = 0; m_len[c] = in_len[c]; m_mode[c] = in_mode[c];
      end else if (ce) begin
        if (m_el[c] + 1 == m_len[c]) begin
          fired = 1;
          m_el[c] = 0;
          m_busy[c] = (m_mode[c] == 2);
        end else begin
          m_el[c] = m_el[c] + 1;
        end
      end
      e.act[c]  = m_busy[c];
      e.done[c] = fired;
      e.cnt[c*CNT_W +: CNT_W] = m_el[c][CNT_W-1:0];
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, '0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (o_active === e.act && o_done === e.done && o_count === e.cnt) n_pass++;
        else $display("FAIL cycle_outputs: got act=%b done=%b cnt=%h expected act=%b done=%b cnt=%h at %0t",
                      o_active, o_done, o_count, e.act, e.done, e.cnt, $time);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    i_nrst = 1'b0; i_ce = 1'b0; i_start = '0; i_abort = '0; i_len = '0; i_mode = '0;
    for (int c = 0; c < N_CH; c++) set_ch(c, 0, 0);
    model_clear();
    #1;
    check("reset_active", 64'(o_active), 64'd0);
    check("reset_done",   64'(o_done),   64'd0);
    check("reset_count",  64'(o_count),  64'd0);
    @(negedge i_clk); @(negedge i_clk);
    i_nrst = 1'b1;

    // one-shot len 5 on ch0
    set_ch(0, 5, 0);
    step(1'b1, 4'b0001, '0);
    idle(8);

    // retrigger on ch1, then the same pattern one-shot on ch2
    set_ch(1, 4, 1);
    step(1'b1, 4'b0010, '0); step(1'b1, '0, '0); step(1'b1, 4'b0010, '0);
    idle(7);
    set_ch(2, 4, 0);
    step(1'b1, 4'b0100, '0); step(1'b1, '0, '0); step(1'b1, 4'b0100, '0);
    idle(6);

    // periodic len 3 on ch2, aborted at t=10
    set_ch(2, 3, 2);
    step(1'b1, 4'b0100, '0);
    idle(9);
    step(1'b1, '0, 4'b0100);
    idle(3);

    // one-shot len 3 with stalled ticks
    set_ch(0, 3, 0);
    step(1'b1, 4'b0001, '0);
    for (int i = 0; i < 10; i++) step(i[0], '0, '0);

    // retrigger coinciding with a terminal tick, mode 11, back-to-back one-shot
    set_ch(1, 2, 1);
    step(1'b1, 4'b0010, '0); step(1'b1, '0, '0); step(1'b1, 4'b0010, '0);
    idle(3);
    set_ch(3, 2, 3);
    step(1'b1, 4'b1000, '0); step(1'b1, '0, '0); step(1'b1, 4'b1000, '0);
    idle(4);

    // zero length and start+abort in IDLE
    set_ch(0, 0, 0);
    step(1'b1, 4'b0001, '0); idle(2);
    set_ch(0, 4, 0);
    step(1'b1, 4'b0001, 4'b0001); idle(2);

    // maximum window length, no wrap
    set_ch(3, (1 << CNT_W) - 1, 0);
    step(1'b1, 4'b1000, '0);
    idle((1 << CNT_W) + 1);

    // all channels together, then async reset between edges
    set_ch(0, 7, 0); set_ch(1, 5, 1); set_ch(2, 3, 2); set_ch(3, 9, 3);
    step(1'b1, 4'b1111, '0);
    idle(4);
    @(posedge i_clk); #2;
    i_nrst = 1'b0;
    #1;
    check("midreset_active", 64'(o_active), 64'd0);
    check("midreset_done",   64'(o_done),   64'd0);
    check("midreset_count",  64'(o_count),  64'd0);
    model_clear();
    @(negedge i_clk);
    i_nrst = 1'b1;
    step(1'b1, 4'b1111, '0);
    idle(12);

    // randomized traffic; inputs change freely while channels count
    for (int i = 0; i < 3000; i++) begin
      logic [N_CH-1:0] st, ab;
      for (int c = 0; c < N_CH; c++) begin
        set_ch(c, ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 9)),
               int'($urandom_range(0, 3)));
        st[c] = ($urandom_range(0, 5) == 0);
        ab[c] = ($urandom_range(0, 29) == 0);
      end
      step($urandom_range(0, 3) != 0, st, ab);
    end
    idle(2);

    @(posedge i_clk); #2;
    if (exp_q.size() != 0) check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
